// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExec     = 4'd3,
    StAluWb    = 4'd4,
    StMemAddr  = 4'd5,
    StMemRead  = 4'd6,
    StMemWb    = 4'd7,
    StMemWrite = 4'd8,
    StIllegal  = 4'd9
  } state_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [2:0] F3Word = 3'b010;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       mdr_write;
    logic       reg_write;
    logic [2:0] imm_ctrl;
    logic [3:0] alu_ctrl;
    logic       alu_in2_ctrl;
    logic       addrsrc_ctrl;
    logic       regwrite_ctrl;
    logic       instr_done;
    logic       illegal_instr;
  } ctrl_out_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the instruction fields to an ALU operation code; non-ALU opcodes yield ADD.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    if (opcode_i == OpR || opcode_i == OpI) begin
      unique case (funct3_i)
        // funct7_5 is part of the immediate for I-type, so SUB is R-type only
        3'b000:  alu_ctrl_o = (opcode_i == OpR && funct7_5_i) ? AluSub : AluAdd;
        3'b001:  alu_ctrl_o = AluSll;
        3'b010:  alu_ctrl_o = AluSlt;
        3'b011:  alu_ctrl_o = AluSltu;
        3'b100:  alu_ctrl_o = AluXor;
        3'b101:  alu_ctrl_o = funct7_5_i ? AluSra : AluSrl;
        3'b110:  alu_ctrl_o = AluOr;
        3'b111:  alu_ctrl_o = AluAnd;
        default: alu_ctrl_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM; outputs are registered decodes of the next state and IR fields.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic [2:0] imm_ctrl,
  output logic [3:0] alu_ctrl,
  output logic       alu_in2_ctrl,
  output logic       addrsrc_ctrl,
  output logic       regwrite_ctrl,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_e    state_q, state_d;
  ctrl_out_t out_q, out_d;
  logic      run_q;
  logic [3:0] dec_alu;
  logic      is_mem_op, mem_bad_width;

  alu_decoder u_alu_decoder (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_5_i(funct7_5),
    .alu_ctrl_o(dec_alu)
  );

  assign is_mem_op     = (opcode == OpLoad) || (opcode == OpStore);
  assign mem_bad_width = STRICT_DECODE && (funct3 != F3Word);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // run_q holds IDLE for one full cycle after reset release
      StIdle:     state_d = run_q ? StFetch : StIdle;
      StFetch:    state_d = StDecode;
      StDecode: begin
        if (opcode == OpR || opcode == OpI) state_d = StExec;
        else if (is_mem_op)                state_d = mem_bad_width ? StIllegal : StMemAddr;
        else                               state_d = StIllegal;
      end
      StExec:     state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StMemAddr:  state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StIllegal:  state_d = StFetch;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = '0;
    unique case (state_d)
      StFetch: begin
        out_d.pc_write = 1'b1;
        out_d.ir_write = 1'b1;
      end
      StExec, StAluWb: begin
        out_d.alu_ctrl     = dec_alu;
        out_d.alu_in2_ctrl = (opcode == OpI);
        out_d.imm_ctrl     = ImmI;
        out_d.reg_write    = (state_d == StAluWb);
        out_d.instr_done   = (state_d == StAluWb);
      end
      StMemAddr, StMemRead, StMemWb, StMemWrite: begin
        out_d.alu_ctrl      = AluAdd;
        out_d.alu_in2_ctrl  = 1'b1;
        out_d.imm_ctrl      = (opcode == OpStore) ? ImmS : ImmI;
        out_d.addrsrc_ctrl  = (state_d == StMemRead) || (state_d == StMemWrite);
        out_d.mdr_write     = (state_d == StMemRead);
        out_d.reg_write     = (state_d == StMemWb);
        out_d.regwrite_ctrl = (state_d == StMemWb);
        out_d.mem_write     = (state_d == StMemWrite);
        out_d.instr_done    = (state_d == StMemWb) || (state_d == StMemWrite);
      end
      StIllegal: out_d.illegal_instr = 1'b1;
      default:   out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      run_q   <= 1'b1;
    end
  end

  assign pc_write      = out_q.pc_write;
  assign ir_write      = out_q.ir_write;
  assign mem_write     = out_q.mem_write;
  assign mdr_write     = out_q.mdr_write;
  assign reg_write     = out_q.reg_write;
  assign imm_ctrl      = out_q.imm_ctrl;
  assign alu_ctrl      = out_q.alu_ctrl;
  assign alu_in2_ctrl  = out_q.alu_in2_ctrl;
  assign addrsrc_ctrl  = out_q.addrsrc_ctrl;
  assign regwrite_ctrl = out_q.regwrite_ctrl;
  assign instr_done    = out_q.instr_done;
  assign illegal_instr = out_q.illegal_instr;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       pc_write, ir_write, mem_write, mdr_write, reg_write;
  logic [2:0] imm_ctrl;
  logic [3:0] alu_ctrl;
  logic       alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl, instr_done, illegal_instr;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.STRICT_DECODE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .mem_write    (mem_write),
    .mdr_write    (mdr_write),
    .reg_write    (reg_write),
    .imm_ctrl     (imm_ctrl),
    .alu_ctrl     (alu_ctrl),
    .alu_in2_ctrl (alu_in2_ctrl),
    .addrsrc_ctrl (addrsrc_ctrl),
    .regwrite_ctrl(regwrite_ctrl),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .state_dbg    (state_dbg)
  );

  // Bit order: state(4) pc ir mem mdr reg imm(3) alu(4) in2 addr rwc done ill
  task automatic chk(input string tag, input logic [3:0] st, input logic [4:0] wr,
                     input logic [2:0] imm, input logic [3:0] alu, input logic in2,
                     input logic addr, input logic rwc, input logic done, input logic ill);
    logic [20:0] obs, exp;
    obs = {state_dbg, pc_write, ir_write, mem_write, mdr_write, reg_write, imm_ctrl,
           alu_ctrl, alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl, instr_done, illegal_instr};
    exp = {st, wr, imm, alu, in2, addr, rwc, done, ill};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  initial begin
    rst = 1'b1;
    set_ir(7'b0, 3'b0, 1'b0);
    #3;
    chk("reset", 4'd0, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    step(); chk("idle_after_rst", 4'd0, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("first_fetch", 4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // ADDI with funct7_5=1 must stay ADD
    set_ir(7'b0010011, 3'b000, 1'b1);
    step(); chk("addi_decode", 4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("addi_exec",   4'd3, 5'b00000, 3'b000, 4'b0000, 1, 0, 0, 0, 0);
    step(); chk("addi_wb",     4'd4, 5'b00001, 3'b000, 4'b0000, 1, 0, 0, 1, 0);
    step(); chk("addi_fetch",  4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // SRA (R-type)
    set_ir(7'b0110011, 3'b101, 1'b1);
    step(); chk("sra_decode", 4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("sra_exec",   4'd3, 5'b00000, 3'b000, 4'b0111, 0, 0, 0, 0, 0);
    step(); chk("sra_wb",     4'd4, 5'b00001, 3'b000, 4'b0111, 0, 0, 0, 1, 0);
    step(); chk("sra_fetch",  4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // SUB
    set_ir(7'b0110011, 3'b000, 1'b1);
    step(); step(); chk("sub_exec", 4'd3, 5'b00000, 3'b000, 4'b0001, 0, 0, 0, 0, 0);
    step(); chk("sub_wb",           4'd4, 5'b00001, 3'b000, 4'b0001, 0, 0, 0, 1, 0);
    step();

    // ORI and XOR
    set_ir(7'b0010011, 3'b110, 1'b0);
    step(); step(); chk("ori_exec", 4'd3, 5'b00000, 3'b000, 4'b0011, 1, 0, 0, 0, 0);
    step(); step();
    set_ir(7'b0110011, 3'b100, 1'b0);
    step(); step(); chk("xor_exec", 4'd3, 5'b00000, 3'b000, 4'b0100, 0, 0, 0, 0, 0);
    step(); step();

    // LW: 5 cycles
    set_ir(7'b0000011, 3'b010, 1'b0);
    step(); chk("lw_decode", 4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("lw_addr",   4'd5, 5'b00000, 3'b000, 4'b0000, 1, 0, 0, 0, 0);
    step(); chk("lw_read",   4'd6, 5'b00010, 3'b000, 4'b0000, 1, 1, 0, 0, 0);
    step(); chk("lw_wb",     4'd7, 5'b00001, 3'b000, 4'b0000, 1, 0, 1, 1, 0);
    step(); chk("lw_fetch",  4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // SW: 4 cycles
    set_ir(7'b0100011, 3'b010, 1'b0);
    step(); chk("sw_decode", 4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("sw_addr",   4'd5, 5'b00000, 3'b001, 4'b0000, 1, 0, 0, 0, 0);
    step(); chk("sw_write",  4'd8, 5'b00100, 3'b001, 4'b0000, 1, 1, 0, 1, 0);
    step(); chk("sw_fetch",  4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // Unknown opcode
    set_ir(7'b1111111, 3'b000, 1'b0);
    step(); chk("bad_decode", 4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("bad_illegal", 4'd9, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 1);
    step(); chk("bad_fetch",  4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // LB rejected under strict decode
    set_ir(7'b0000011, 3'b000, 1'b0);
    step(); chk("lb_decode",  4'd2, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("lb_illegal", 4'd9, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 1);
    step(); chk("lb_fetch",   4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of MEM_READ
    set_ir(7'b0000011, 3'b010, 1'b0);
    step(); step(); step();
    chk("lw2_read", 4'd6, 5'b00010, 3'b000, 4'b0000, 1, 1, 0, 0, 0);
    #2; rst = 1'b1;
    #1; chk("async_rst", 4'd0, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); #0;
    rst = 1'b0;
    step(); chk("rel_idle",  4'd0, 5'b00000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);
    step(); chk("rel_fetch", 4'd1, 5'b11000, 3'b000, 4'b0000, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
